// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit: radix-2 shift-add multiply and restoring divide, results in HI/LO.
// Define MULDIV_SIGNED_EN to build the signed MULT/DIV path; otherwise op[0] is ignored.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

   state_t             r_state, w_state_next;
   logic               r_busy, w_busy_next;
   logic               r_done, w_done_next;
   logic               r_dz;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic [5:0]         r_cnt;
   logic               r_is_div, r_bz, r_neg_q, r_neg_r;
   logic [WIDTH-1:0]   r_a_orig, r_x;
   logic [2*WIDTH-1:0] r_acc;

   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic               w_neg_q, w_neg_r;
   logic [WIDTH:0]     w_add, w_shift, w_trial;
   logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
   logic [WIDTH-1:0]   w_quo, w_rem;

`ifdef MULDIV_SIGNED_EN
   logic w_signed, w_a_neg, w_b_neg;
   assign w_signed = ~op[0];
   assign w_a_neg  = w_signed & opA[WIDTH-1];
   assign w_b_neg  = w_signed & opB[WIDTH-1];
   assign w_mag_a  = w_a_neg ? -opA : opA;
   assign w_mag_b  = w_b_neg ? -opB : opB;
   assign w_neg_q  = w_a_neg ^ w_b_neg;
   assign w_neg_r  = w_a_neg;
   assign w_prod   = r_neg_q ? -r_acc : r_acc;
   assign w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`else
   logic w_unused_op0;
   assign w_unused_op0 = op[0];
   assign w_mag_a  = opA;
   assign w_mag_b  = opB;
   assign w_neg_q  = 1'b0;
   assign w_neg_r  = 1'b0;
   assign w_prod   = r_acc;
   assign w_quo    = r_acc[WIDTH-1:0];
   assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
`endif

   // Multiply: add multiplicand into upper half when the low bit is set, then shift right.
   assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_x} : '0);
   assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

   // Divide: upper half is the remainder, lower half shifts dividend out and quotient in.
   assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, r_x};
   assign w_div_next = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   always_comb begin
      w_state_next = r_state;
      w_busy_next  = r_busy;
      w_done_next  = 1'b0;
      case (r_state)
         S_IDLE: if (start) begin
            w_state_next = S_CALC;
            w_busy_next  = 1'b1;
         end
         S_CALC: if (r_cnt == LAST_ITER) w_state_next = S_FIX;
         S_FIX: begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
         end
         default: begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_bz     <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_a_orig <= '0;
         r_x      <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dz     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_cnt    <= '0;
               r_is_div <= op[1];
               r_bz     <= (opB == '0);
               r_neg_q  <= w_neg_q;
               r_neg_r  <= w_neg_r;
               r_a_orig <= opA;
               // Multiply iterates over the multiplier (B); divide over the dividend (A).
               r_x      <= op[1] ? w_mag_b : w_mag_a;
               r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
            end
            S_CALC: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + 6'd1;
            end
            S_FIX: begin
               r_dz <= r_is_div & r_bz;
               if (!r_is_div) begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end else if (r_bz) begin
                  r_hi <= r_a_orig;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign dz   = r_dz;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
